// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and transfer-size constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    typedef enum logic {PORT_A, PORT_B} port_id_t;

    localparam int unsigned XFER_1       = 1;
    localparam int unsigned XFER_2       = 2;
    localparam int unsigned XFER_4       = 4;
    localparam int unsigned XFER_8       = 8;
    localparam int unsigned XFER_DEFAULT = XFER_8;

    function automatic logic legal_size(input int unsigned s);
        return s == XFER_1 || s == XFER_2 || s == XFER_4 || s == XFER_8;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick; the pointer register lives in the caller.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic     req_a,
    input  logic     req_b,
    input  port_id_t last,
    output port_id_t winner,
    output logic     any_req
);

    assign any_req = req_a | req_b;
    assign winner  = (req_a && req_b) ? ((last == PORT_A) ? PORT_B : PORT_A)
                                      : (req_a ? PORT_A : PORT_B);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the datamem port between CPU (A) and DMA (B), IDLE->ACCESS->DONE per access.
// Define DMEM_ARB_PERF_EN to add saturating grant and conflict counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [SIZE_W-1:0] a_size,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [SIZE_W-1:0] b_size,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [SIZE_W-1:0] mem_xfer_size,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_a_grants,
    output logic [31:0]       perf_b_grants,
    output logic [31:0]       perf_conflict
`endif
);

    arb_state_t        state_q, state_d;
    port_id_t          owner_q, owner_d, rr_last_q, rr_last_d, winner;
    logic              any_req, start, win_a;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [SIZE_W-1:0] size_q, size_d, win_size;
    logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic              a_rv_q, a_rv_d, b_rv_q, b_rv_d;
    logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;

    rr_arbiter2 u_rr (
        .req_a   (a_req),
        .req_b   (b_req),
        .last    (rr_last_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign start    = state_q == IDLE && any_req;
    assign win_a    = winner == PORT_A;
    assign win_size = win_a ? a_size : b_size;

    // Strobes are computed one cycle ahead so every port-facing control is a flop.
    always_comb begin
        state_d   = start ? ACCESS : (state_q == ACCESS ? DONE : IDLE);
        owner_d   = start ? winner : owner_q;
        rr_last_d = start ? winner : rr_last_q;
        we_d      = start ? (win_a ? a_we : b_we) : we_q;
        addr_d    = start ? (win_a ? a_addr : b_addr) : addr_q;
        wdata_d   = start ? (win_a ? a_wdata : b_wdata) : wdata_q;
        size_d    = start ? (legal_size(32'(win_size)) ? win_size : SIZE_W'(XFER_DEFAULT)) : size_q;
        rdata_d   = state_q == ACCESS ? mem_read_data : rdata_q;
        a_gnt_d   = start && win_a;
        b_gnt_d   = start && !win_a;
        mem_we_d  = start && we_d;
        mem_re_d  = start && !we_d;
        a_rv_d    = state_q == ACCESS && owner_q == PORT_A;
        b_rv_d    = state_q == ACCESS && owner_q == PORT_B;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= PORT_A;
            rr_last_q <= PORT_B;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            rdata_q   <= '0;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_rv_q    <= 1'b0;
            b_rv_q    <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_re_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            rdata_q   <= rdata_d;
            a_gnt_q   <= a_gnt_d;
            b_gnt_q   <= b_gnt_d;
            a_rv_q    <= a_rv_d;
            b_rv_q    <= b_rv_d;
            mem_we_q  <= mem_we_d;
            mem_re_q  <= mem_re_d;
        end
    end

    assign a_gnt            = a_gnt_q;
    assign b_gnt            = b_gnt_q;
    assign a_rvalid         = a_rv_q;
    assign b_rvalid         = b_rv_q;
    assign a_rdata          = a_rv_q ? rdata_q : '0;
    assign b_rdata          = b_rv_q ? rdata_q : '0;
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign mem_xfer_size    = size_q;
    assign mem_write_enable = mem_we_q;
    assign mem_read_enable  = mem_re_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_a_q, perf_b_q, perf_c_q;
    logic        a_wait, b_wait;

    // A port is waiting when it asks but neither holds nor is finishing the current access.
    assign a_wait = a_req && !(state_q != IDLE && owner_q == PORT_A) && !a_rv_q;
    assign b_wait = b_req && !(state_q != IDLE && owner_q == PORT_B) && !b_rv_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_a_q <= '0;
            perf_b_q <= '0;
            perf_c_q <= '0;
        end else begin
            perf_a_q <= perf_a_q + {31'd0, a_gnt_q && perf_a_q != '1};
            perf_b_q <= perf_b_q + {31'd0, b_gnt_q && perf_b_q != '1};
            perf_c_q <= perf_c_q + {31'd0, (a_wait || b_wait) && perf_c_q != '1};
        end
    end

    assign perf_a_grants = perf_a_q;
    assign perf_b_grants = perf_b_q;
    assign perf_conflict = perf_c_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus random requests checked against a transaction-level schedule model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rq = '0, rwe = '0;
    logic [63:0] raddr[2], rwdata[2];
    logic [3:0]  rsize[2];

    logic        a_req, a_we, b_req, b_we;
    logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_size, b_size;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [63:0] a_rdata, b_rdata;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable;
    logic [3:0]  mem_xfer_size;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_a_grants, perf_b_grants, perf_conflict;
`endif

    assign a_req = rq[0];
    assign a_we = rwe[0];
    assign a_addr = raddr[0];
    assign a_wdata = rwdata[0];
    assign a_size = rsize[0];
    assign b_req = rq[1];
    assign b_we = rwe[1];
    assign b_addr = raddr[1];
    assign b_wdata = rwdata[1];
    assign b_size = rsize[1];

    dmem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_size(a_size),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_size(b_size),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
        .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data)
`ifdef DMEM_ARB_PERF_EN
        , .perf_a_grants(perf_a_grants), .perf_b_grants(perf_b_grants), .perf_conflict(perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] seed(input int i);
        return (i == 2) ? 64'hDEADBEEF : {32'hA5A5A5A5, 28'd0, 4'(i)};
    endfunction

    function automatic logic [63:0] bit64(input logic x);
        return {63'd0, x};
    endfunction

    // Behavioural datamem: combinational read, write on the clock edge.
    logic [63:0] dev_mem[16];
    assign mem_read_data = dev_mem[mem_address[6:3]];
    always @(posedge clk) begin
        if (!reset_n) for (int i = 0; i < 16; i++) dev_mem[i] <= seed(i);
        else if (mem_write_enable) dev_mem[mem_address[6:3]] <= mem_write_data;
    end

    int          n_tests = 0, n_fail = 0;
    int          t = 0, next_free = 0, p_t = 0;
    bit          pv, p_own, p_we, rr_last, hold = 0, rand_en = 0, log_order = 0;
    bit          committed[2];
    logic [63:0] p_addr, p_wdata, p_rdata, last_addr, last_wdata;
    logic [3:0]  p_size, last_size;
    logic [63:0] ref_mem[16];
    int          q_order[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        pv = 0;
        rr_last = 1;
        committed[0] = 0;
        committed[1] = 0;
        last_addr = '0;
        last_wdata = '0;
        last_size = '0;
        next_free = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = seed(i);
    endtask

    // Arbitration decision on the inputs the DUT will see at the next rising edge.
    task automatic decide();
        bit w;
        if (reset_n && !pv && t >= next_free && (rq[0] || rq[1])) begin
            w = (rq[0] && rq[1]) ? !rr_last : !rq[0];
            rr_last = w;
            pv = 1;
            p_t = t + 1;
            p_own = w;
            p_we = rwe[w];
            p_addr = raddr[w];
            p_wdata = rwdata[w];
            p_size = (rsize[w] inside {4'd1, 4'd2, 4'd4, 4'd8}) ? rsize[w] : 4'd8;
            p_rdata = ref_mem[raddr[w][6:3]];
            committed[w] = 1;
            next_free = t + 3;
            last_addr = p_addr;
            last_wdata = p_wdata;
            last_size = p_size;
        end
    endtask

    task automatic cycle();
        bit acc, dn;
        @(negedge clk);
        t++;
        acc = pv && t == p_t;
        dn = pv && t == p_t + 1;
        check("a_gnt", bit64(a_gnt), bit64(acc && !p_own));
        check("b_gnt", bit64(b_gnt), bit64(acc && p_own));
        check("mem_we", bit64(mem_write_enable), bit64(acc && p_we));
        check("mem_re", bit64(mem_read_enable), bit64(acc && !p_we));
        check("mem_addr", mem_address, last_addr);
        check("mem_wdata", mem_write_data, last_wdata);
        check("mem_size", 64'(mem_xfer_size), 64'(last_size));
        check("a_rvalid", bit64(a_rvalid), bit64(dn && !p_own));
        check("b_rvalid", bit64(b_rvalid), bit64(dn && p_own));
        if (dn && !p_we) check("owner_rdata", p_own ? b_rdata : a_rdata, p_rdata);
        if (dn) check("other_rdata", p_own ? a_rdata : b_rdata, 64'd0);
        if (log_order && a_gnt) q_order.push_back(0);
        if (log_order && b_gnt) q_order.push_back(1);
        if (dn) begin
            pv = 0;
            committed[p_own] = 0;
            if (p_we) ref_mem[p_addr[6:3]] = p_wdata;
            if (!hold) rq[p_own] = 0;
        end
        if (rand_en) begin
            for (int p = 0; p < 2; p++) begin
                if (!committed[p]) begin
                    if (rq[p]) begin
                        if ($urandom_range(0, 9) == 0) rq[p] = 0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        rq[p] = 1;
                        rwe[p] = 1'($urandom_range(0, 1));
                        raddr[p] = 64'($urandom_range(0, 127));
                        rwdata[p] = {$urandom, $urandom};
                        rsize[p] = 4'($urandom_range(0, 15));
                    end
                end
            end
        end
        decide();
    endtask

    task automatic issue(input int p, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [3:0] size);
        rq[p] = 1;
        rwe[p] = we;
        raddr[p] = addr;
        rwdata[p] = wdata;
        rsize[p] = size;
        decide();
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            raddr[p] = '0;
            rwdata[p] = '0;
            rsize[p] = '0;
        end
        model_reset();
        repeat (2) cycle();
        reset_n = 1;
        // Single read of the preloaded word at 0x10, then B writes 0x20 and A reads it back.
        issue(0, 0, 64'h10, 64'h0, 4'd8);
        repeat (4) cycle();
        issue(1, 1, 64'h20, 64'h1234, 4'd8);
        repeat (3) cycle();
        issue(0, 0, 64'h20, 64'h0, 4'd8);
        repeat (4) cycle();
        // Illegal size 3 must reach datamem as 8.
        issue(0, 1, 64'h28, 64'hCAFE, 4'd3);
        repeat (3) cycle();
        // Reset asserted during a write's ACCESS cycle.
        issue(1, 1, 64'h30, 64'h5555, 4'd8);
        cycle();
        reset_n = 0;
        #1;
        check("rst_mem_we", bit64(mem_write_enable), 64'd0);
        check("rst_b_gnt", bit64(b_gnt), 64'd0);
        model_reset();
        rq = '0;
        cycle();
        reset_n = 1;
        repeat (3) cycle();
        // Both ports requesting continuously after reset: grants must alternate A, B, A, B.
        raddr[0] = 64'h08;
        raddr[1] = 64'h40;
        rwe = '0;
        rsize[0] = 4'd8;
        rsize[1] = 4'd8;
        rq = 2'b11;
        hold = 1;
        log_order = 1;
        decide();
        repeat (12) cycle();
        log_order = 0;
        check("order_len", 64'(q_order.size()), 64'd4);
        for (int i = 0; i < q_order.size() && i < 4; i++) check("order", 64'(q_order[i]), 64'(i % 2));
`ifdef DMEM_ARB_PERF_EN
        check("perf_a", 64'(perf_a_grants), 64'd2);
        check("perf_b", 64'(perf_b_grants), 64'd2);
        check("perf_conf_nz", bit64(perf_conflict != 0), 64'd1);
`endif
        hold = 0;
        for (int p = 0; p < 2; p++) if (!committed[p]) rq[p] = 0;
        rand_en = 1;
        repeat (500) cycle();
        rand_en = 0;
        for (int p = 0; p < 2; p++) if (!committed[p]) rq[p] = 0;
        repeat (5) cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (datamem) between two requesters: the CPU load/store path (port A) and a DMA/debug loader (port B).
- Arbitrates round-robin and registers the winning request.
- Sequences each access through a fixed 3-cycle IDLE→ACCESS→DONE flow and returns read data with a one-cycle valid pulse.
- Sits between the memory stage and datamem; the CPU uses a_req && !a_rvalid as its stall condition.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- SIZE_W, 4, transfer-size width; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- a_req  input  1  CPU request; held high and stable until a_rvalid.
- a_we  input  1  CPU write (1) / read (0).
- a_addr  input  ADDR_W  CPU byte address.
- a_wdata  input  DATA_W  CPU write data.
- a_size  input  SIZE_W  CPU transfer size.
- a_gnt  output  1  one-cycle pulse: CPU request accepted.
- a_rvalid  output  1  one-cycle pulse: CPU access complete.
- a_rdata  output  DATA_W  CPU read data; valid while a_rvalid is high.
- b_req, b_we, b_addr, b_wdata, b_size, b_gnt, b_rvalid, b_rdata: same as port A, for DMA.
- mem_address  output  ADDR_W  to datamem.address.
- mem_write_enable  output  1  to datamem.write_enable.
- mem_read_enable  output  1  to datamem.read_enable.
- mem_write_data  output  DATA_W  to datamem.write_data.
- mem_xfer_size  output  SIZE_W  to datamem.xfer_size.
- mem_read_data  input  DATA_W  from datamem.read_data (combinational read).

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rr_last=B (so A wins the first conflict).
  - All outputs 0; latched request registers 0.
- IDLE:
  - If neither req is high, stay.
  - If exactly one req is high, that port wins.
  - If both are high, the port not equal to rr_last wins.
  - On the edge: latch winner's we/addr/wdata/size and owner; set rr_last=owner; go to ACCESS.
- ACCESS (1 cycle):
  - owner's gnt=1.
  - mem_address, mem_write_data, mem_xfer_size come from latched registers.
  - mem_write_enable=latched we; mem_read_enable=!latched we.
  - On the edge: capture mem_read_data into rdata_q (writes capture too; value is don't-care); go to DONE.
- DONE (1 cycle):
  - owner's rvalid=1 and owner's rdata=rdata_q.
  - req inputs are ignored; go to IDLE.
- Outside ACCESS:
  - mem_write_enable=0 and mem_read_enable=0.
  - mem_address/data/size hold last latched values.
- The non-owner's rdata is 0.
- Latency: req high in IDLE → rvalid exactly 2 cycles later.
- Back-to-back: peak throughput is 1 access per 3 cycles. A requester keeping req high after rvalid is re-arbitrated in the next IDLE.
- Fairness: with both ports continuously requesting, grants alternate A, B, A, …; neither port waits more than one other access.
- Size sanitising: a size not in {1,2,4,8} is latched as 8.
- Misaligned addresses are passed through unmodified; datamem checks alignment.
- Request dropped while not yet granted: no access occurs, and no state or rr_last change.
- Request dropped after grant: the access still completes and rvalid is still pulsed.
- Reset mid-ACCESS: mem_write_enable drops immediately (async). No rvalid is issued and the pending request is discarded.

Optional Feature:
- Macro DMEM_ARB_PERF_EN adds outputs perf_a_grants[31:0], perf_b_grants[31:0] and perf_conflict[31:0].
  - perf_a_grants / perf_b_grants: +1 per gnt pulse of the respective port.
  - perf_conflict: +1 per cycle in which a port has req=1, is not the current owner, and no rvalid is pulsing to it.
  - All counters saturate at 0xFFFF_FFFF and reset to 0.
- Without the macro: these ports and counters do not exist; the core behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, ACCESS, DONE};
  - typedef enum logic {PORT_A, PORT_B} port_id_t;
  - constants XFER_1/2/4/8 and XFER_DEFAULT=8.
- Sub-module rr_arbiter2 is natural: inputs req_a, req_b and last; output winner and any_req. It is purely combinational, so the pointer update stays in dmem_arbiter.

Test Plan:
- Single read: a_req=1, a_we=0, a_addr=0x10, mem holds 0xDEADBEEF at 0x10 → a_gnt in cycle 1, mem_read_enable=1 and mem_address=0x10 in cycle 1, a_rvalid=1 and a_rdata=0xDEADBEEF in cycle 2.
- Write then read: b writes 0x1234 to 0x20, then a reads 0x20 → mem_write_enable high exactly 1 cycle with mem_write_data=0x1234; a_rdata=0x1234.
- Conflict after reset: a_req and b_req both asserted → grant order A, B, A, B over 4 accesses (12 cycles); each rvalid only to its owner.
- Illegal size: a_size=3 → mem_xfer_size=8 during ACCESS.
- Reset mid-ACCESS: reset_n=0 during a write's ACCESS cycle → mem_write_enable falls with no clock edge; no b_rvalid; state=IDLE after release.
- With DMEM_ARB_PERF_EN: the conflict scenario above → after 12 cycles perf_a_grants=2, perf_b_grants=2, perf_conflict>0. Also force perf_conflict to 0xFFFF_FFFE, run 3 conflict cycles → stays 0xFFFF_FFFF.
